// File: rtl/bls_search_ctrl_if.sv
// Control bus of the basic-layer integer search sequencer: request handshake, PE array pins, ref memory read pins.
// With BLS_ABORT_EN defined the bus also carries the abort request.
interface bls_search_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic              busy;
  logic              done;
  logic              in_curr_enable;
  logic              CB_select;
  logic [1:0]        abs_Control;
  logic              ref_input_Control;
  logic              change_ref;
  logic              rd8R_en;
  logic [ADDR_W-4:0] rdR_sel;
  logic [ADDR_W-1:0] rd_address;
`ifdef BLS_ABORT_EN
  logic              abort;

  modport master (
    input  start, abort,
    output busy, done, in_curr_enable, CB_select, abs_Control,
           ref_input_Control, change_ref, rd8R_en, rdR_sel, rd_address
  );
  modport slave (
    output start, abort,
    input  busy, done, in_curr_enable, CB_select, abs_Control,
           ref_input_Control, change_ref, rd8R_en, rdR_sel, rd_address
  );
`else
  modport master (
    input  start,
    output busy, done, in_curr_enable, CB_select, abs_Control,
           ref_input_Control, change_ref, rd8R_en, rdR_sel, rd_address
  );
  modport slave (
    output start,
    input  busy, done, in_curr_enable, CB_select, abs_Control,
           ref_input_Control, change_ref, rd8R_en, rdR_sel, rd_address
  );
`endif
endinterface

// File: rtl/bls_search_ctrl.sv
// Sequencer for one integer-search block: LOAD -> PRE -> SRCH -> DRAIN -> DONE, all outputs registered.
// Optional macro BLS_ABORT_EN adds an abort request that returns the FSM to IDLE without a done pulse.
module bls_search_ctrl #(
  parameter int CURR_ROWS   = 64,
  parameter int PRE_ROWS    = 8,
  parameter int SEARCH_ROWS = 128,
  parameter int DRAIN_CYC   = 4,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  bls_search_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_SRCH  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int M_A   = (CURR_ROWS > SEARCH_ROWS) ? CURR_ROWS : SEARCH_ROWS;
  localparam int M_B   = (PRE_ROWS > DRAIN_CYC) ? PRE_ROWS : DRAIN_CYC;
  localparam int CNT_W = $clog2(((M_A > M_B) ? M_A : M_B) + 1);

  // Zero-length PRE/DRAIN never reach their own state, so their all-ones last value is harmless.
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(CURR_ROWS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_ROWS - 1);
  localparam logic [CNT_W-1:0] SRCH_LAST  = CNT_W'(SEARCH_ROWS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [2:0] AFTER_LOAD = (PRE_ROWS > 0) ? S_PRE : S_SRCH;
  localparam logic [2:0] AFTER_SRCH = (DRAIN_CYC > 0) ? S_DRAIN : S_DONE;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy, r_done, r_in_curr, r_cb, r_ref_in, r_change_ref, r_rd8r;
  logic [1:0]        r_abs;
  logic [ADDR_W-1:0] r_rd_address;

  logic [2:0]        w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_accept, w_kill;
  logic [1:0]        w_abs_next;
  logic [ADDR_W-1:0] w_addr_next;

  assign w_accept = (r_state == S_IDLE) && bus.start;
`ifdef BLS_ABORT_EN
  assign w_kill = (r_state != S_IDLE) && bus.abort;
`else
  assign w_kill = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (bus.start) w_state_next = S_LOAD;
      end
      S_LOAD:  if (r_cnt == LOAD_LAST)  begin w_state_next = AFTER_LOAD; w_cnt_next = '0; end
      S_PRE:   if (r_cnt == PRE_LAST)   begin w_state_next = S_SRCH;     w_cnt_next = '0; end
      S_SRCH:  if (r_cnt == SRCH_LAST)  begin w_state_next = AFTER_SRCH; w_cnt_next = '0; end
      S_DRAIN: if (r_cnt == DRAIN_LAST) begin w_state_next = S_DONE;     w_cnt_next = '0; end
      default: begin w_state_next = S_IDLE; w_cnt_next = '0; end
    endcase
    if (w_kill) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    w_abs_next  = 2'b00;
    w_addr_next = '0;
    case (w_state_next)
      S_PRE:   w_addr_next = ADDR_W'(w_cnt_next);
      S_SRCH: begin
        w_addr_next = ADDR_W'(PRE_ROWS) + ADDR_W'(w_cnt_next);
        w_abs_next  = (w_cnt_next == '0) ? 2'b10 : 2'b01;
      end
      S_DRAIN: w_abs_next = 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_in_curr    <= 1'b0;
      r_cb         <= 1'b0;
      r_abs        <= 2'b00;
      r_ref_in     <= 1'b0;
      r_change_ref <= 1'b0;
      r_rd8r       <= 1'b0;
      r_rd_address <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_done       <= (w_state_next == S_DONE);
      r_in_curr    <= (w_state_next == S_LOAD);
      r_abs        <= w_abs_next;
      r_ref_in     <= (w_state_next == S_PRE);
      r_change_ref <= (w_state_next == S_SRCH);
      r_rd8r       <= (w_state_next == S_PRE) || (w_state_next == S_SRCH);
      r_rd_address <= w_addr_next;
      if (w_kill)        r_cb <= 1'b0;
      else if (w_accept) r_cb <= ~r_cb;
    end
  end

  assign bus.busy              = r_busy;
  assign bus.done              = r_done;
  assign bus.in_curr_enable    = r_in_curr;
  assign bus.CB_select         = r_cb;
  assign bus.abs_Control       = r_abs;
  assign bus.ref_input_Control = r_ref_in;
  assign bus.change_ref        = r_change_ref;
  assign bus.rd8R_en           = r_rd8r;
  assign bus.rd_address        = r_rd_address;
  assign bus.rdR_sel           = r_rd_address[ADDR_W-1:3];

endmodule

// File: tb/tb_bls_search_ctrl.sv
// Directed bench for bls_search_ctrl: default and reduced-parameter instances, cycle traces against a timeline model.
// Abort scenarios are exercised when BLS_ABORT_EN is defined.
module tb_bls_search_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bls_search_ctrl_if #(.ADDR_W(7)) bus_m ();
  bls_search_ctrl_if #(.ADDR_W(7)) bus_s ();

  bls_search_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  bls_search_ctrl #(
    .CURR_ROWS(2), .PRE_ROWS(0), .SEARCH_ROWS(4), .DRAIN_CYC(0), .ADDR_W(7)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // {busy,done,in_curr,CB,abs[1:0],ref_in,change_ref,rd8R,rdR_sel[3:0],rd_address[6:0]}
  function automatic logic [19:0] snap_m();
    return {bus_m.busy, bus_m.done, bus_m.in_curr_enable, bus_m.CB_select, bus_m.abs_Control,
            bus_m.ref_input_Control, bus_m.change_ref, bus_m.rd8R_en, bus_m.rdR_sel, bus_m.rd_address};
  endfunction

  function automatic logic [19:0] snap_s();
    return {bus_s.busy, bus_s.done, bus_s.in_curr_enable, bus_s.CB_select, bus_s.abs_Control,
            bus_s.ref_input_Control, bus_s.change_ref, bus_s.rd8R_en, bus_s.rdR_sel, bus_s.rd_address};
  endfunction

  // Expected outputs j cycles after the accepting edge, from the state timeline.
  function automatic logic [19:0] exp_trace(input int j, input logic cb,
                                            input int c, input int p, input int s, input int d);
    logic busy, done, load, pre, srch, drain;
    logic [1:0] abs_c;
    logic [6:0] addr;
    busy  = (j >= 1) && (j <= c + p + s + d + 1);
    done  = (j == c + p + s + d + 1);
    load  = (j >= 1) && (j <= c);
    pre   = (j > c) && (j <= c + p);
    srch  = (j > c + p) && (j <= c + p + s);
    drain = (j > c + p + s) && (j <= c + p + s + d);
    abs_c = (j == c + p + 1) ? 2'b10 : ((srch || drain) ? 2'b01 : 2'b00);
    addr  = pre ? 7'(j - c - 1) : (srch ? 7'((p + j - c - p - 1) % 128) : 7'd0);
    return {busy, done, load, cb, abs_c, pre, srch, pre | srch, addr[6:3], addr};
  endfunction

  int done1, done2, n_curr, n_rd8r, n_chg, n_done, n_cb_tog;
  logic cb_prev;

  initial begin
    rst_n = 1'b0;
    bus_m.start = 1'b0;
    bus_s.start = 1'b0;
`ifdef BLS_ABORT_EN
    bus_m.abort = 1'b0;
    bus_s.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_main", 32'(snap_m()), 32'h0);
    chk("reset_small", 32'(snap_s()), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two back-to-back blocks; starts during LOAD and DONE must be ignored.
    bus_m.start = 1'b1;
    @(negedge clk);
    bus_m.start = 1'b0;
    done1 = 0; done2 = 0; n_curr = 0; n_rd8r = 0; n_chg = 0; n_done = 0; n_cb_tog = 0;
    cb_prev = bus_m.CB_select;
    for (int k = 1; k <= 414; k++) begin
      int j;
      logic cb;
      j  = (k <= 206) ? k : k - 206;
      cb = (k <= 206);
      chk($sformatf("trace_k%0d", k), 32'(snap_m()), 32'(exp_trace(j, cb, 64, 8, 128, 4)));
      if (k <= 206) begin
        if (bus_m.in_curr_enable) n_curr++;
        if (bus_m.rd8R_en)        n_rd8r++;
        if (bus_m.change_ref)     n_chg++;
      end
      if (bus_m.done) begin
        n_done++;
        if (done1 == 0) done1 = k; else if (done2 == 0) done2 = k;
      end
      if (bus_m.CB_select != cb_prev) n_cb_tog++;
      cb_prev = bus_m.CB_select;
      if (k == 73)  chk("abs_first_srch", 32'(bus_m.abs_Control), 32'h2);
      if (k == 193) chk("addr_wrap", 32'(bus_m.rd_address), 32'h0);
      bus_m.start = (k == 50) || (k == 205) || (k == 206);
      @(negedge clk);
    end
    bus_m.start = 1'b0;
    chk("in_curr_cycles", 32'(n_curr), 32'd64);
    chk("rd8r_cycles", 32'(n_rd8r), 32'd136);
    chk("change_ref_cycles", 32'(n_chg), 32'd128);
    chk("done_first_at", 32'(done1), 32'd205);
    chk("done_second_at", 32'(done2), 32'd411);
    chk("done_pulses", 32'(n_done), 32'd2);
    chk("cb_toggles", 32'(n_cb_tog), 32'd1);
    $display("block main_pair done at +%0d and +%0d", done1, done2);

    // Reduced parameters: PRE and DRAIN skipped.
    bus_s.start = 1'b1;
    @(negedge clk);
    bus_s.start = 1'b0;
    done1 = 0; n_chg = 0; n_curr = 0;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("small_k%0d", k), 32'(snap_s()), 32'(exp_trace(k, 1'b1, 2, 0, 4, 0)));
      if (bus_s.done && done1 == 0) done1 = k;
      if (bus_s.change_ref) n_chg++;
      if (bus_s.ref_input_Control) n_curr++;
      @(negedge clk);
    end
    chk("small_done_at", 32'(done1), 32'd7);
    chk("small_change_ref", 32'(n_chg), 32'd4);
    chk("small_no_pre", 32'(n_curr), 32'd0);
    $display("block small done at +%0d", done1);

    // Asynchronous reset in the middle of SRCH.
    bus_m.start = 1'b1;
    @(negedge clk);
    bus_m.start = 1'b0;
    for (int k = 1; k < 100; k++) @(negedge clk);
    chk("pre_reset_srch", 32'(bus_m.change_ref), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(snap_m()), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("reset_hold%0d", k), 32'(snap_m()), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_release", 32'(snap_m()), 32'h0);
    bus_m.start = 1'b1;
    @(negedge clk);
    bus_m.start = 1'b0;
    done1 = 0;
    for (int k = 1; k <= 207; k++) begin
      chk($sformatf("rerun_k%0d", k), 32'(snap_m()), 32'(exp_trace(k, 1'b1, 64, 8, 128, 4)));
      if (bus_m.done && done1 == 0) done1 = k;
      @(negedge clk);
    end
    chk("rerun_done_at", 32'(done1), 32'd205);
    $display("block after_reset done at +%0d", done1);

`ifdef BLS_ABORT_EN
    bus_m.start = 1'b1;
    @(negedge clk);
    bus_m.start = 1'b0;
    for (int k = 1; k < 70; k++) @(negedge clk);
    chk("pre_abort_busy", 32'(bus_m.busy), 32'h1);
    bus_m.abort = 1'b1;
    @(negedge clk);
    bus_m.abort = 1'b0;
    chk("abort_busy", 32'(bus_m.busy), 32'h0);
    chk("abort_rd8r", 32'(bus_m.rd8R_en), 32'h0);
    n_done = 0;
    for (int k = 0; k < 140; k++) begin
      if (bus_m.done) n_done++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_idle", 32'(snap_m()), 32'h0);
    bus_m.start = 1'b1;
    bus_m.abort = 1'b1;
    @(negedge clk);
    bus_m.start = 1'b0;
    chk("start_abort_busy", 32'(bus_m.busy), 32'h1);
    chk("start_abort_load", 32'(bus_m.in_curr_enable), 32'h1);
    @(negedge clk);
    bus_m.abort = 1'b0;
    chk("abort_in_load", 32'(bus_m.busy), 32'h0);
    $display("block abort scenarios complete");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
